// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the accumulator CPU: word store, direct/indirect access and host program loader.
// Optional macro MEM_WRITE_PROTECT_EN drops CPU writes below PROT_LIMIT and flags them on prot_err.
module cpu_mem_responder #(
   parameter int AW         = 10,
   parameter int DW         = 16,
   parameter int PROT_LIMIT = 64
) (
   input  logic          clk,
   input  logic          rst_mem_n,
   input  logic [AW-1:0] addr,
   input  logic          wr,
   input  logic          addr_mode,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          stall,
   output logic          cpu_hold,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          load_done,
   output logic          prot_err
);

`ifdef MEM_WRITE_PROTECT_EN
   localparam bit ProtEn = 1'b1;
`else
   localparam bit ProtEn = 1'b0;
`endif
   localparam logic [AW:0] ProtLim = (AW+1)'(PROT_LIMIT);

   typedef enum logic [1:0] {RUN, INDIR, LOAD} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          done_q, done_d;
   logic          prot_q, prot_d;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] memAtAddr, memAtPtr;
   logic          memWe, cpuWe;
   logic [AW-1:0] memWaddr, cpuAddr;
   logic [DW-1:0] memWdata;

   assign memAtAddr = mem[addr];
   assign memAtPtr  = mem[ptr_q];

   // Single write port shared by the CPU path and the loader; the CPU path is
   // only ever active outside LOAD, so the two never compete.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      prot_d   = prot_q;
      memWe    = 1'b0;
      memWaddr = cnt_q;
      memWdata = ld_data;
      cpuWe    = 1'b0;
      cpuAddr  = addr;
      case (state_q)
         RUN: begin
            if (addr_mode) begin
               ptr_d   = memAtAddr[AW-1:0];
               pend_d  = ld_start;
               state_d = INDIR;
            end else begin
               rdata_d = memAtAddr;
               cpuWe   = wr;
               if (ld_start) begin
                  cnt_d   = '0;
                  state_d = LOAD;
               end
            end
         end
         INDIR: begin
            rdata_d = memAtPtr;
            cpuWe   = wr;
            cpuAddr = ptr_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
            state_d = (pend_q || ld_start) ? LOAD : RUN;
         end
         LOAD: begin
            if (ld_valid) begin
               memWe = 1'b1;
               cnt_d = cnt_q + AW'(1);
               // Reaching the top address ends the load so address 0 is never overwritten.
               if (ld_last || (cnt_q == '1)) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         default: state_d = RUN;
      endcase

      if (cpuWe) begin
         if (ProtEn && ({1'b0, cpuAddr} < ProtLim)) begin
            prot_d = 1'b1;
         end else begin
            memWe    = 1'b1;
            memWaddr = cpuAddr;
            memWdata = wdata;
         end
      end
   end

   // Control state; memory contents deliberately survive reset.
   always_ff @(posedge clk or negedge rst_mem_n) begin
      if (!rst_mem_n) begin
         state_q <= RUN;
         ptr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         prot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         prot_q  <= prot_d;
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[memWaddr] <= memWdata;
      end
   end

   assign rdata     = rdata_q;
   assign stall     = (state_q == INDIR);
   assign cpu_hold  = (state_q == LOAD);
   assign ld_ready  = (state_q == LOAD);
   assign load_done = done_q;
   assign prot_err  = prot_q;

endmodule
